// File: rtl/rf_wb_sched.sv
// rf_wb_sched - write-back scheduler for the register file's single write port.
//
// Several execute-stage units (ALU, LSU, MUL/DIV, ...) compete for one RF
// write port. A round-robin arbiter grants one of them per cycle. The granted
// write is registered once and then driven straight onto RFWr/A3/WD. A
// pending-write scoreboard (one bit per architectural register) lets decode
// stall on RAW hazards against instructions whose result has not committed yet.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_addr/req_data     packed per-requester dest reg / write data
//   iss_valid/iss_rd      decode issues a writer of iss_rd (sets scoreboard)
//   chk_a1/chk_a2         decode source operands checked against scoreboard
//   hazard                a source operand has a write still in flight
//   rf_wr/rf_a3/rf_wd     register file write port
//   pend                  scoreboard contents, for visibility
module rf_wb_sched #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        chk_a1,
  input  logic [AW-1:0]        chk_a2,
  output logic                 hazard,
  output logic                 rf_wr,
  output logic [AW-1:0]        rf_a3,
  output logic [DW-1:0]        rf_wd,
  output logic [(2**AW)-1:0]   pend
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2**AW;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_wr_q,  rf_wr_d;
  logic [AW-1:0]   rf_a3_q,  rf_a3_d;
  logic [DW-1:0]   rf_wd_q,  rf_wd_d;
  logic [NREG-1:0] pend_q,   pend_d;

  logic            xfer;
  logic [PW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  int              scan_idx;

  // Round-robin scan: start at rr_ptr, wrap, take the first valid requester.
  // Reset suppresses the grant so nothing is accepted and then lost.
  always_comb begin
    xfer     = 1'b0;
    gnt_idx  = '0;
    scan_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!xfer && req_valid[scan_idx]) begin
        xfer    = 1'b1;
        gnt_idx = PW'(scan_idx);
      end
    end
    if (rst) begin
      xfer = 1'b0;
    end
    gnt      = xfer ? (NREQ'(1) << gnt_idx) : '0;
    gnt_addr = req_addr[int'(gnt_idx)*AW +: AW];
    gnt_data = req_data[int'(gnt_idx)*DW +: DW];
  end

  assign req_ready = gnt;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end

    // Writes to r0 complete the handshake but never reach the register file.
    rf_wr_d = xfer && (gnt_addr != '0);
    rf_a3_d = rf_a3_q;
    rf_wd_d = rf_wd_q;
    if (rf_wr_d) begin
      rf_a3_d = gnt_addr;
      rf_wd_d = gnt_data;
    end

    // Clear happens on the edge the RF commits; a same-cycle issue to the
    // same register is a newer producer, so the set is applied last and wins.
    pend_d = pend_q;
    if (rf_wr_q) begin
      pend_d[rf_a3_q] = 1'b0;
    end
    if (iss_valid && (iss_rd != '0)) begin
      pend_d[iss_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rf_wr_q  <= 1'b0;
      rf_a3_q  <= '0;
      rf_wd_q  <= '0;
      pend_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rf_wr_q  <= rf_wr_d;
      rf_a3_q  <= rf_a3_d;
      rf_wd_q  <= rf_wd_d;
      pend_q   <= pend_d;
    end
  end

  // No bypass: the hazard only drops once the committing edge has cleared pend.
  assign hazard = ((chk_a1 != '0) && pend_q[chk_a1]) ||
                  ((chk_a2 != '0) && pend_q[chk_a2]);

  assign rf_wr = rf_wr_q;
  assign rf_a3 = rf_a3_q;
  assign rf_wd = rf_wd_q;
  assign pend  = pend_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
module tb_rf_wb_sched;

  localparam int N    = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 2**AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_data;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic [AW-1:0]     chk_a1;
  logic [AW-1:0]     chk_a2;
  logic              hazard;
  logic              rf_wr;
  logic [AW-1:0]     rf_a3;
  logic [DW-1:0]     rf_wd;
  logic [NREG-1:0]   pend;

  logic [AW-1:0]     ra [N];
  logic [DW-1:0]     rd [N];

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = ra[i];
      req_data[i*DW +: DW] = rd[i];
    end
  end

  rf_wb_sched #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_a1(chk_a1), .chk_a2(chk_a2),
    .hazard(hazard),
    .rf_wr(rf_wr), .rf_a3(rf_a3), .rf_wd(rf_wd),
    .pend(pend)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the scheduler.
  int              m_ptr;
  bit              m_wr;
  bit [AW-1:0]     m_a3;
  bit [DW-1:0]     m_wd;
  bit [NREG-1:0]   m_pend;
  int              last_g;

  function automatic int m_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Compare DUT against the model for the current inputs (call at negedge).
  task automatic model_check();
    int g;
    logic [N-1:0] e_rdy;
    bit e_haz;
    g = rst ? -1 : m_grant(req_valid, m_ptr);
    e_rdy = (g < 0) ? '0 : (N'(1) << g);
    e_haz = ((chk_a1 != 0) && m_pend[chk_a1]) || ((chk_a2 != 0) && m_pend[chk_a2]);
    chk("m_ready",  64'(req_ready), 64'(e_rdy));
    chk("m_hazard", 64'(hazard),    64'(e_haz));
    chk("m_rf_wr",  64'(rf_wr),     64'(m_wr));
    chk("m_rf_a3",  64'(rf_a3),     64'(m_a3));
    chk("m_rf_wd",  64'(rf_wd),     64'(m_wd));
    chk("m_pend",   64'(pend),      64'(m_pend));
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_step();
    int g;
    bit [NREG-1:0] np;
    if (rst) begin
      m_ptr = 0; m_wr = 0; m_a3 = '0; m_wd = '0; m_pend = '0; last_g = -1;
    end else begin
      g = m_grant(req_valid, m_ptr);
      last_g = g;
      np = m_pend;
      if (m_wr) np[m_a3] = 1'b0;
      if (iss_valid && iss_rd != 0) np[iss_rd] = 1'b1;
      if (g >= 0) begin
        m_wr = (ra[g] != 0);
        if (ra[g] != 0) begin
          m_a3 = ra[g];
          m_wd = rd[g];
        end
        m_ptr = (g + 1) % N;
      end else begin
        m_wr = 1'b0;
      end
      m_pend = np;
    end
  endtask

  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [N-1:0]  rv;
    logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic [AW-1:0] a2; logic [DW-1:0] d2;
    logic          iv;
    logic [AW-1:0] ird;
    logic [AW-1:0] c1;
    logic [AW-1:0] c2;
    logic [N-1:0]  e_rdy;
    logic          e_haz;
    logic          e_wr;
    logic [AW-1:0] e_a3;
    logic [DW-1:0] e_wd;
  } vec_t;

  vec_t tbl [12];
  int   gcnt [N];

  initial begin
    rst = 1'b1; req_valid = '0; iss_valid = 1'b0; iss_rd = '0;
    chk_a1 = '0; chk_a2 = '0;
    for (int i = 0; i < N; i++) begin ra[i] = '0; rd[i] = '0; end
    m_ptr = 0; m_wr = 0; m_a3 = '0; m_wd = '0; m_pend = '0; last_g = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset holds ready low even with every requester valid.
    req_valid = 3'b111;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    finish_cycle();

    // Idle after reset: no writes, empty scoreboard.
    rst = 1'b0; req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_rf_wr", 64'(rf_wr), 64'd0);
      chk("idle_pend",  64'(pend),  64'd0);
      finish_cycle();
    end

    //         rst rv      a0  d0            a1  d1            a2  d2            iv ird c1 c2  rdy  haz wr a3  wd
    tbl[0]  = '{1, 3'b111, 0,  0,            0,  0,            0,  0,            0, 0,  0, 0,  0,   0,  0, 0,  0};
    tbl[1]  = '{0, 3'b011, 3,  32'hAAAA0003, 4,  32'hBBBB0004, 0,  0,            0, 0,  0, 0,  1,   0,  0, 0,  0};
    tbl[2]  = '{0, 3'b010, 3,  32'hAAAA0003, 4,  32'hBBBB0004, 0,  0,            0, 0,  0, 0,  2,   0,  1, 3,  32'hAAAA0003};
    tbl[3]  = '{0, 3'b000, 0,  0,            0,  0,            0,  0,            1, 7,  7, 0,  0,   0,  1, 4,  32'hBBBB0004};
    tbl[4]  = '{0, 3'b100, 0,  0,            0,  0,            7,  32'h77777777, 0, 0,  7, 0,  4,   1,  0, 4,  32'hBBBB0004};
    tbl[5]  = '{0, 3'b000, 0,  0,            0,  0,            0,  0,            0, 0,  7, 0,  0,   1,  1, 7,  32'h77777777};
    tbl[6]  = '{0, 3'b000, 0,  0,            0,  0,            0,  0,            0, 0,  7, 0,  0,   0,  0, 7,  32'h77777777};
    tbl[7]  = '{0, 3'b001, 9,  32'h99999999, 0,  0,            0,  0,            0, 0,  9, 0,  1,   0,  0, 7,  32'h77777777};
    tbl[8]  = '{0, 3'b000, 0,  0,            0,  0,            0,  0,            1, 9,  9, 0,  0,   0,  1, 9,  32'h99999999};
    tbl[9]  = '{0, 3'b010, 0,  0,            0,  32'h0000DEAD, 0,  0,            0, 0,  9, 0,  2,   1,  0, 9,  32'h99999999};
    tbl[10] = '{0, 3'b000, 0,  0,            0,  0,            0,  0,            0, 0,  0, 9,  0,   1,  0, 9,  32'h99999999};
    tbl[11] = '{0, 3'b000, 0,  0,            0,  0,            0,  0,            0, 0,  0, 5,  0,   0,  0, 9,  32'h99999999};

    for (int r = 0; r < 12; r++) begin
      rst = tbl[r].rst; req_valid = tbl[r].rv;
      ra[0] = tbl[r].a0; rd[0] = tbl[r].d0;
      ra[1] = tbl[r].a1; rd[1] = tbl[r].d1;
      ra[2] = tbl[r].a2; rd[2] = tbl[r].d2;
      iss_valid = tbl[r].iv; iss_rd = tbl[r].ird;
      chk_a1 = tbl[r].c1; chk_a2 = tbl[r].c2;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", r),  64'(req_ready), 64'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_hazard", r), 64'(hazard),    64'(tbl[r].e_haz));
      chk($sformatf("tbl%0d_rf_wr", r),  64'(rf_wr),     64'(tbl[r].e_wr));
      chk($sformatf("tbl%0d_rf_a3", r),  64'(rf_a3),     64'(tbl[r].e_a3));
      chk($sformatf("tbl%0d_rf_wd", r),  64'(rf_wd),     64'(tbl[r].e_wd));
      finish_cycle();
    end
    iss_valid = 1'b0; chk_a1 = '0; chk_a2 = '0;

    // pend[9] must have survived the same-cycle set/clear.
    @(negedge clk);
    chk("pend9_after_set_clear", 64'(pend[9]), 64'd1);
    finish_cycle();

    // Fairness: all requesters held valid for 9 cycles from a fresh pointer.
    rst = 1'b1; req_valid = '0;
    @(negedge clk); finish_cycle();
    rst = 1'b0; req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      ra[i] = AW'(10 + i); rd[i] = 32'hC0DE0000 + i; gcnt[i] = 0;
    end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(N'(1) << (c % N)));
      for (int i = 0; i < N; i++) if (req_ready[i]) gcnt[i]++;
      finish_cycle();
    end
    req_valid = '0;
    for (int i = 0; i < N; i++) chk($sformatf("rr_count%0d", i), 64'(gcnt[i]), 64'd3);

    // Reset the cycle after a transfer to r5 whose issue set pend[5].
    rst = 1'b1; @(negedge clk); finish_cycle();
    rst = 1'b0; iss_valid = 1'b1; iss_rd = 5; req_valid = 3'b001; ra[0] = 5; rd[0] = 32'h55555555;
    @(negedge clk); finish_cycle();
    iss_valid = 1'b0; req_valid = '0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_inflight_wr", 64'(rf_wr), 64'd1);
    chk("midrst_pend5",       64'(pend[5]), 64'd1);
    chk("midrst_ready",       64'(req_ready), 64'd0);
    finish_cycle();
    rst = 1'b0; req_valid = 3'b111;
    @(negedge clk);
    chk("postrst_rf_wr", 64'(rf_wr), 64'd0);
    chk("postrst_pend",  64'(pend), 64'd0);
    chk("postrst_ptr0",  64'(req_ready), 64'd1);
    finish_cycle();
    req_valid = '0;

    // Randomized traffic checked cycle-by-cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      if (last_g >= 0 && !rst) req_valid[last_g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          ra[i] = AW'($urandom_range(0, 7));
          rd[i] = $urandom;
        end
      end
      rst       = ($urandom_range(0, 63) == 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = AW'($urandom_range(0, 7));
      chk_a1    = AW'($urandom_range(0, 7));
      chk_a2    = AW'($urandom_range(0, 7));
      @(negedge clk);
      finish_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
